// File: rtl/switch_debounce.sv
// Switch input conditioning for the LED stage.
//
// Purpose: brings a raw mechanical switch into the clk domain through a
// two-flop synchroniser. The synchronised level is then accepted as the new
// debounced level only after it has differed from the current level for
// STABLE_CYCLES consecutive enabled cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       filter advance enable; low freezes the filter (not the synchroniser)
//   switch_raw   asynchronous raw switch level
//   switch       debounced level
//   rise         one-cycle pulse on an accepted 0->1
//   fall         one-cycle pulse on an accepted 1->0
//   toggle       flips on every accepted rise
//   press_count  number of accepted rises, wraps 255->0
module switch_debounce #(
   parameter  int unsigned STABLE_CYCLES = 4,
   localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       switch_raw,
   output logic       switch,
   output logic       rise,
   output logic       fall,
   output logic       toggle,
   output logic [7:0] press_count
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   logic             switch_q, switch_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             toggle_q, toggle_d;
   logic [7:0]       press_count_q, press_count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync0_d       = switch_raw;
      sync1_d       = sync0_q;
      switch_d      = switch_q;
      rise_d        = 1'b0;
      fall_d        = 1'b0;
      toggle_d      = toggle_q;
      press_count_d = press_count_q;
      cnt_d         = cnt_q;

      if (enable) begin
         if (sync1_q == switch_q) begin
            // Any return to the current level restarts the whole window.
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            switch_d = sync1_q;
            cnt_d    = '0;
            rise_d   = sync1_q;
            fall_d   = ~sync1_q;
            if (sync1_q) begin
               toggle_d      = ~toggle_q;
               press_count_d = press_count_q + 8'd1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_q       <= 1'b0;
         sync1_q       <= 1'b0;
         switch_q      <= 1'b0;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
         toggle_q      <= 1'b0;
         press_count_q <= 8'd0;
         cnt_q         <= '0;
      end else begin
         sync0_q       <= sync0_d;
         sync1_q       <= sync1_d;
         switch_q      <= switch_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         toggle_q      <= toggle_d;
         press_count_q <= press_count_d;
         cnt_q         <= cnt_d;
      end
   end

   assign switch      = switch_q;
   assign rise        = rise_q;
   assign fall        = fall_q;
   assign toggle      = toggle_q;
   assign press_count = press_count_q;

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditioning stage directly upstream of the switch-driven LED block.
- Synchronises a raw, bouncy mechanical switch input and debounces it with a stable-count filter.
- Produces a clean level plus single-cycle rise/fall pulses, a toggle state and an 8-bit press counter for the downstream LED stage.

Parameters:
STABLE_CYCLES, 4, consecutive enabled cycles the synchronised input must differ from the current debounced level before it is accepted; legal range 1..65535.
CNT_W, $clog2(STABLE_CYCLES+1), width of the internal stability counter; derived, not overridden.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  filter advance enable; low freezes the filter
switch_raw  input  1  asynchronous raw switch level
switch  output  1  debounced level
rise  output  1  one-cycle pulse on accepted 0->1
fall  output  1  one-cycle pulse on accepted 1->0
toggle  output  1  flips on every accepted rise
press_count  output  8  count of accepted rises, wraps 255->0

Behaviour:
- Reset (rst=1 at a rising edge): sync0, sync1, switch, rise, fall, toggle = 0; press_count = 0; cnt = 0. rst has priority over enable and all other activity.
- Synchroniser: sync0 <= switch_raw; sync1 <= sync0, every cycle regardless of enable. Only sync1 feeds the filter.
- Filter, when enable=1:
  - sync1 == switch: cnt <= 0.
  - sync1 != switch and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - sync1 != switch and cnt == STABLE_CYCLES-1: switch <= sync1; cnt <= 0; rise or fall set for the next cycle.
- Filter, when enable=0: cnt and switch hold; rise = fall = 0; toggle and press_count hold. The synchroniser keeps running.
- Pulses: rise/fall are registered, high for exactly one cycle, and never both high together. An accept cannot occur on two consecutive cycles because cnt restarts from 0.
- On an accept with rise: toggle <= ~toggle; press_count <= press_count+1 (modulo 256). On an accept with fall: neither changes.
- Latency: raw level held stable, first edge sampling it = edge 1. switch and the pulse update at edge STABLE_CYCLES+2, assuming enable=1 throughout. Each enable=0 cycle adds one cycle.
- Glitch rejection: if sync1 returns to the switch level before cnt reaches STABLE_CYCLES-1, cnt clears to 0 and there is no output change. Any bounce restarts the full qualification window.
- STABLE_CYCLES=1: accept on the first enabled cycle sync1 differs. Latency is 3 edges.
- Reset mid-qualification: discards the partial count. After reset the filter compares against switch=0, so a raw input held high re-qualifies from scratch and produces a rise.
- No combinational path from any input to any output.

Test Plan:
- Reset then clean press (STABLE_CYCLES=4, enable=1): raw 0->1 held -> switch=1 and rise=1 after edge 6; rise low at edge 7; toggle=1; press_count=1.
- Bounce: raw pattern 1,0,1,1,0 (one cycle each) then held 1 -> no rise during the bounces; single rise 6 edges after the final 0->1 sample; press_count increments by exactly 1.
- Release: from switch=1, raw held 0 -> fall pulse for one cycle at edge 6; toggle and press_count unchanged; rise stays 0.
- Enable gating: press with enable=0 for 3 cycles mid-qualification -> accept delayed by 3 cycles; no pulses while enable=0.
- Wrap: 256 clean press/release pairs -> press_count returns to 0; toggle back at its reset value (0).
- Mid-operation reset: rst=1 for one cycle at cnt=2 with raw held 1 -> all outputs 0 on the next cycle; rise occurs 6 edges after rst deasserts.
